// File: rtl/user_ram_pkg.sv
// ---------------------------------------------------------------------------
// user_ram_pkg : shared types and helpers for user_ram_be          rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package user_ram_pkg;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   localparam logic [31:0] IDLE_WORD_DEFAULT = 32'h1611_0400;

   function automatic int nbe_of(input int data_w);
      return data_w / 8;
   endfunction

endpackage

`default_nettype wire

// File: rtl/user_ram_bank.sv
// ---------------------------------------------------------------------------
// user_ram_bank : DEPTH x DATA_W byte-writable array, registered read  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module user_ram_bank
   import user_ram_pkg::*;
#(
   parameter int ADDR_BIT = 8,
   parameter int DATA_W   = 32,
   parameter int NBE      = nbe_of(DATA_W)
) (
   input  logic                clk,
   input  logic [NBE-1:0]      be,
   input  logic [ADDR_BIT-1:0] addr,
   input  logic [DATA_W-1:0]   wdata,
   input  logic                re,
   output logic [DATA_W-1:0]   rdata
);

   // No reset on the array or read register so the tools map this onto BRAM.
   logic [DATA_W-1:0] mem [2**ADDR_BIT];

   always_ff @(posedge clk) begin
      for (int k = 0; k < NBE; k++) begin
         if (be[k]) begin
            mem[addr][8*k +: 8] <= wdata[8*k +: 8];
         end
      end
      if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

`default_nettype wire

// File: rtl/user_ram_be.sv
// ---------------------------------------------------------------------------
// user_ram_be : byte-enable scratch RAM with clear engine, valid/ready port  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module user_ram_be
   import user_ram_pkg::*;
#(
   parameter int          ADDR_BIT  = 8,
   parameter int          DATA_W    = 32,
   parameter int          READ_LAT  = 1,
   parameter logic [31:0] IDLE_WORD = IDLE_WORD_DEFAULT,
   localparam int         NBE       = nbe_of(DATA_W)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                clr_i,
   output logic                busy_o,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic                req_we_i,
   input  logic [NBE-1:0]      req_be_i,
   input  logic [ADDR_BIT-1:0] req_addr_i,
   input  logic [DATA_W-1:0]   req_wdata_i,
   output logic                rsp_valid_o,
   output logic [DATA_W-1:0]   rsp_rdata_o
);

   localparam int                DEPTH     = 2**ADDR_BIT;
   localparam logic [ADDR_BIT:0] LAST_ADDR = (ADDR_BIT+1)'(DEPTH - 1);
   localparam logic [DATA_W-1:0] IDLE_VAL  = DATA_W'(IDLE_WORD);

   state_t              state;
   state_t              state_next;
   logic [ADDR_BIT:0]   clr_addr;
   logic [ADDR_BIT:0]   clr_addr_next;
   logic                accept;
   logic                rd_accept;
   logic                rd_pend;
   logic [NBE-1:0]      bank_be;
   logic [ADDR_BIT-1:0] bank_addr;
   logic [DATA_W-1:0]   bank_wdata;
   logic [DATA_W-1:0]   bank_rdata;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state    <= ST_CLEAR;
         clr_addr <= '0;
      end else begin
         state    <= state_next;
         clr_addr <= clr_addr_next;
      end
   end

   always_comb begin
      state_next    = state;
      clr_addr_next = clr_addr;
      busy_o        = 1'b1;
      req_ready_o   = 1'b0;
      case (state)
         ST_CLEAR: begin
            clr_addr_next = clr_addr + 1'b1;
            if (clr_addr == LAST_ADDR) begin
               state_next = ST_READY;
            end
         end
         ST_READY: begin
            busy_o      = 1'b0;
            req_ready_o = 1'b1;
            if (clr_i) begin
               clr_addr_next = '0;
               state_next    = ST_CLEAR;
            end
         end
         default: state_next = ST_CLEAR;
      endcase
   end

   assign accept    = req_valid_i & req_ready_o;
   assign rd_accept = accept & ~req_we_i;

   // The clear engine owns the write port whenever it runs; requests are blocked then.
   always_comb begin
      bank_be    = '0;
      bank_addr  = req_addr_i;
      bank_wdata = req_wdata_i;
      if (state == ST_CLEAR) begin
         bank_be    = '1;
         bank_addr  = clr_addr[ADDR_BIT-1:0];
         bank_wdata = '0;
      end else if (accept && req_we_i) begin
         bank_be    = req_be_i;
      end
   end

   user_ram_bank #(
      .ADDR_BIT (ADDR_BIT),
      .DATA_W   (DATA_W),
      .NBE      (NBE)
   ) u_bank (
      .clk   (clk_i),
      .be    (bank_be),
      .addr  (bank_addr),
      .wdata (bank_wdata),
      .re    (rd_accept),
      .rdata (bank_rdata)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rd_pend <= 1'b0;
      end else begin
         rd_pend <= rd_accept;
      end
   end

   generate
      if (READ_LAT <= 1) begin : g_lat1
         assign rsp_valid_o = rd_pend;
         assign rsp_rdata_o = rd_pend ? bank_rdata : IDLE_VAL;
      end else begin : g_lat2
         logic              vld2;
         logic [DATA_W-1:0] data2;

         always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
               vld2  <= 1'b0;
               data2 <= '0;
            end else begin
               vld2  <= rd_pend;
               data2 <= bank_rdata;
            end
         end

         assign rsp_valid_o = vld2;
         assign rsp_rdata_o = vld2 ? data2 : IDLE_VAL;
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_user_ram_be.sv
// ---------------------------------------------------------------------------
// tb_user_ram_be : directed self-checking bench, READ_LAT=1 and 2 side by side  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_user_ram_be;

   localparam logic [31:0] IDLE = 32'h1611_0400;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        clr_i;
   logic        req_valid;
   logic        req_we;
   logic [3:0]  req_be;
   logic [3:0]  req_addr;
   logic [31:0] req_wdata;

   logic        busy1, ready1, v1;
   logic [31:0] d1;
   logic        busy2, ready2, v2;
   logic [31:0] d2;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   user_ram_be #(.ADDR_BIT(4), .DATA_W(32), .READ_LAT(1)) u_lat1 (
      .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i), .busy_o(busy1),
      .req_valid_i(req_valid), .req_ready_o(ready1), .req_we_i(req_we),
      .req_be_i(req_be), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .rsp_valid_o(v1), .rsp_rdata_o(d1)
   );

   user_ram_be #(.ADDR_BIT(4), .DATA_W(32), .READ_LAT(2)) u_lat2 (
      .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i), .busy_o(busy2),
      .req_valid_i(req_valid), .req_ready_o(ready2), .req_we_i(req_we),
      .req_be_i(req_be), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .rsp_valid_o(v2), .rsp_rdata_o(d2)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (busy1 && n < 100) begin
         step();
         n++;
      end
   endtask

   task automatic do_write(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
      req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_be = be; req_wdata = d;
      step();
      req_valid = 1'b0; req_we = 1'b0;
   endtask

   task automatic do_read(input logic [3:0] a, input logic [31:0] exp, input string name);
      req_valid = 1'b1; req_we = 1'b0; req_addr = a;
      step();
      req_valid = 1'b0;
      checks++;
      if (v1 !== 1'b1 || d1 !== exp) begin
         failures++;
         $display("FAIL %s lat1: valid=%b data=%h, required valid=1 data=%h", name, v1, d1, exp);
      end
      checks++;
      if (v2 !== 1'b0 || d2 !== IDLE) begin
         failures++;
         $display("FAIL %s lat2_early: valid=%b data=%h, required valid=0 data=%h", name, v2, d2, IDLE);
      end
      step();
      checks++;
      if (v2 !== 1'b1 || d2 !== exp) begin
         failures++;
         $display("FAIL %s lat2: valid=%b data=%h, required valid=1 data=%h", name, v2, d2, exp);
      end
      checks++;
      if (v1 !== 1'b0 || d1 !== IDLE) begin
         failures++;
         $display("FAIL %s lat1_after: valid=%b data=%h, required valid=0 data=%h", name, v1, d1, IDLE);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      checks++;
      if (busy1 !== 1'b1 || ready1 !== 1'b0 || v1 !== 1'b0 || d1 !== IDLE) begin
         failures++;
         $display("FAIL %s lat1: busy=%b ready=%b valid=%b data=%h, required 1 0 0 %h",
                  name, busy1, ready1, v1, d1, IDLE);
      end
      checks++;
      if (busy2 !== 1'b1 || ready2 !== 1'b0 || v2 !== 1'b0 || d2 !== IDLE) begin
         failures++;
         $display("FAIL %s lat2: busy=%b ready=%b valid=%b data=%h, required 1 0 0 %h",
                  name, busy2, ready2, v2, d2, IDLE);
      end
   endtask

   task automatic check_clear_len(input int n, input string name);
      checks++;
      if (n !== 16 || ready1 !== 1'b1 || ready2 !== 1'b1) begin
         failures++;
         $display("FAIL %s: busy cycles=%0d ready=%b/%b, required 16 cycles ready=1/1",
                  name, n, ready1, ready2);
      end
   endtask

   task automatic test_reset;
      int n;
      rst_i = 1'b0; clr_i = 1'b0; req_valid = 1'b0; req_we = 1'b0;
      req_be = '0; req_addr = '0; req_wdata = '0;
      step();
      step();
      check_reset_outputs("reset_values");
      rst_i = 1'b1;
      count_busy(n);
      check_clear_len(n, "reset_clear_len");
      for (int a = 0; a < 16; a++) begin
         do_read(4'(a), 32'h0, "cleared_word");
      end
   endtask

   task automatic test_byte_enable;
      do_write(4'd3, 4'b1111, 32'hDEAD_BEEF);
      do_write(4'd3, 4'b0001, 32'h0000_00AA);
      do_read(4'd3, 32'hDEAD_BEAA, "be_low_byte");
      do_write(4'd3, 4'b0000, 32'hFFFF_FFFF);
      do_read(4'd3, 32'hDEAD_BEAA, "be_none");
      do_write(4'd3, 4'b1010, 32'h1122_3344);
      do_read(4'd3, 32'h11AD_33AA, "be_lanes_1_3");
   endtask

   task automatic test_idle;
      step();
      step();
      checks++;
      if (v1 !== 1'b0 || d1 !== IDLE || v2 !== 1'b0 || d2 !== IDLE) begin
         failures++;
         $display("FAIL idle_word: valid=%b/%b data=%h/%h, required 0/0 %h", v1, v2, d1, d2, IDLE);
      end
   endtask

   task automatic test_back_to_back;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd5; req_be = 4'hF; req_wdata = 32'h1234_5678;
      step();
      req_we = 1'b0;
      do_read(4'd5, 32'h1234_5678, "raw_next_cycle");
      req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd3;
      step();
      req_addr = 4'd5;
      checks++;
      if (v1 !== 1'b1 || d1 !== 32'h11AD_33AA) begin
         failures++;
         $display("FAIL pipe_rd0_lat1: valid=%b data=%h, required 1 11ad33aa", v1, d1);
      end
      step();
      req_valid = 1'b0;
      checks++;
      if (v1 !== 1'b1 || d1 !== 32'h1234_5678 || v2 !== 1'b1 || d2 !== 32'h11AD_33AA) begin
         failures++;
         $display("FAIL pipe_mid: lat1 %b %h lat2 %b %h, required lat1 1 12345678 lat2 1 11ad33aa",
                  v1, d1, v2, d2);
      end
      step();
      checks++;
      if (v1 !== 1'b0 || v2 !== 1'b1 || d2 !== 32'h1234_5678) begin
         failures++;
         $display("FAIL pipe_rd1_lat2: lat1 valid=%b lat2 %b %h, required 0 and 1 12345678", v1, v2, d2);
      end
   endtask

   task automatic test_clear_with_read;
      int n;
      int spurious;
      spurious = 0;
      clr_i = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd3;
      step();
      clr_i = 1'b0; req_valid = 1'b0;
      checks++;
      if (busy1 !== 1'b1 || ready1 !== 1'b0 || v1 !== 1'b1 || d1 !== 32'h11AD_33AA) begin
         failures++;
         $display("FAIL clr_read_lat1: busy=%b ready=%b valid=%b data=%h, required 1 0 1 11ad33aa",
                  busy1, ready1, v1, d1);
      end
      n = 1;
      step();
      checks++;
      if (v2 !== 1'b1 || d2 !== 32'h11AD_33AA) begin
         failures++;
         $display("FAIL clr_read_lat2: valid=%b data=%h, required 1 11ad33aa", v2, d2);
      end
      while (busy1 && n < 100) begin
         clr_i     = (n == 5);
         req_valid = (n == 5);
         step();
         n++;
         if (v1 || v2) spurious++;
      end
      clr_i = 1'b0; req_valid = 1'b0;
      check_clear_len(n, "clr_len_ignores_reclear");
      checks++;
      if (spurious !== 0) begin
         failures++;
         $display("FAIL clr_no_accept: responses during clear=%0d, required 0", spurious);
      end
      do_read(4'd3, 32'h0, "after_clear_a3");
      do_read(4'd5, 32'h0, "after_clear_a5");
   endtask

   task automatic test_reset_mid;
      int n;
      int spurious;
      spurious = 0;
      do_write(4'd5, 4'hF, 32'hCAFE_F00D);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd5;
      step();
      req_valid = 1'b0;
      rst_i = 1'b0;
      #1;
      check_reset_outputs("reset_mid_read");
      for (int i = 0; i < 3; i++) begin
         step();
         if (v1 || v2) spurious++;
      end
      checks++;
      if (spurious !== 0) begin
         failures++;
         $display("FAIL reset_drops_read: responses=%0d, required 0", spurious);
      end
      rst_i = 1'b1;
      count_busy(n);
      check_clear_len(n, "reset_read_clear_len");
      clr_i = 1'b1;
      step();
      clr_i = 1'b0;
      for (int i = 0; i < 6; i++) step();
      rst_i = 1'b0;
      #1;
      check_reset_outputs("reset_mid_clear");
      step();
      rst_i = 1'b1;
      count_busy(n);
      check_clear_len(n, "clear_restart_len");
      do_read(4'd5, 32'h0, "after_restart_a5");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_byte_enable();
      test_idle();
      test_back_to_back();
      test_clear_with_read();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
